// File: rtl/p4_router_ingress_dwrr_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : p4_router_pkg                                                  |
// | Purpose : Shared types and width helpers for the P4 router ingress       |
// |           DWRR scheduler and its round-robin picker.                     |
// | Contents: dwrr_state_t    - scheduler state encoding                     |
// |           deficit_width() - signed deficit width for a given MTU/quantum |
// |           index_width()   - encoded port index width, minimum 1 bit      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package p4_router_pkg;

    typedef enum logic [1:0] {
        ARB       = 2'd0,
        REPLENISH = 2'd1,
        XFER      = 2'd2
    } dwrr_state_t;

    // Two guard bits: one for sign, one so a full quantum can be added to a
    // deficit that is still carrying up to an MTU of debt.
    function automatic int deficit_width(input int mtu_bytes, input int quantum_width);
        return $clog2(mtu_bytes + (2 ** quantum_width)) + 2;
    endfunction

    function automatic int index_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

    function automatic int wrap_add(input int base, input int offset, input int modulus);
        return (base + offset) % modulus;
    endfunction

endpackage
`default_nettype wire

// File: rtl/p4_router_ingress_dwrr_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : p4_router_ingress_dwrr_sched_if                              |
// | Purpose   : Request/config inputs, merged-bus beat observation and grant |
// |             outputs of the ingress DWRR scheduler.                       |
// | Modports  : master - scheduler side (drives grant, status)               |
// |             slave  - port/bus side (drives requests, beat observation)   |
// | Signals   : port_req, port_enable, quantum, xfer_valid, xfer_last,       |
// |             xfer_bytes, grant, grant_valid, grant_index, deficit,        |
// |             replenish_cnt                                                |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
interface p4_router_ingress_dwrr_sched_if
    import p4_router_pkg::*;
#(
    parameter int NUM_PORTS     = 4,
    parameter int QUANTUM_WIDTH = 16,
    parameter int MTU_BYTES     = 9600,
    parameter int BUS_BYTES     = 64,
    parameter int DEFICIT_WIDTH = deficit_width(MTU_BYTES, QUANTUM_WIDTH)
) ();
    localparam int IDX_W   = index_width(NUM_PORTS);
    localparam int BYTES_W = $clog2(BUS_BYTES + 1);

    logic [NUM_PORTS-1:0]                     port_req;
    logic [NUM_PORTS-1:0]                     port_enable;
    logic [NUM_PORTS-1:0][QUANTUM_WIDTH-1:0]  quantum;
    logic                                     xfer_valid;
    logic                                     xfer_last;
    logic [BYTES_W-1:0]                       xfer_bytes;
    logic [NUM_PORTS-1:0]                     grant;
    logic                                     grant_valid;
    logic [IDX_W-1:0]                         grant_index;
    logic [NUM_PORTS-1:0][DEFICIT_WIDTH-1:0]  deficit;
    logic [31:0]                              replenish_cnt;

    modport master (
        input  port_req, port_enable, quantum, xfer_valid, xfer_last, xfer_bytes,
        output grant, grant_valid, grant_index, deficit, replenish_cnt
    );

    modport slave (
        output port_req, port_enable, quantum, xfer_valid, xfer_last, xfer_bytes,
        input  grant, grant_valid, grant_index, deficit, replenish_cnt
    );

endinterface
`default_nettype wire

// File: rtl/p4_router_ingress_dwrr_sched_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : p4_router_rr_pick                                              |
// | Purpose : Combinational rotate-priority encoder. Returns the first set   |
// |           request at or after ptr, wrapping around.                      |
// | Ports   : req    in  NUM_PORTS  request vector                           |
// |           ptr    in  IDX_W      starting search position                 |
// |           onehot out NUM_PORTS  selected request, one-hot                |
// |           index  out IDX_W      selected request, encoded                |
// |           any    out 1          at least one request set                 |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module p4_router_rr_pick
    import p4_router_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = index_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] onehot,
    output logic [IDX_W-1:0]     index,
    output logic                 any
);
    always_comb begin
        onehot = '0;
        index  = '0;
        any    = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!any && req[wrap_add(int'(ptr), k, NUM_PORTS)]) begin
                any    = 1'b1;
                index  = IDX_W'(wrap_add(int'(ptr), k, NUM_PORTS));
                onehot[wrap_add(int'(ptr), k, NUM_PORTS)] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/p4_router_ingress_dwrr_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : p4_router_ingress_dwrr_sched                                   |
// | Purpose : Packet-aware deficit-weighted round-robin grant controller for |
// |           the ingress merge point. Grants are held until tlast of the    |
// |           granted packet; each port earns a byte share set by quantum.   |
// | Ports   : clk_ifc     in  core clock                                     |
// |           sreset_ifc  in  synchronous active-high reset                  |
// |           bus         master modport: port_req/port_enable/quantum in,   |
// |                       xfer_valid/last/bytes in, grant/grant_valid/       |
// |                       grant_index/deficit/replenish_cnt out              |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module p4_router_ingress_dwrr_sched
    import p4_router_pkg::*;
#(
    parameter int NUM_PORTS     = 4,
    parameter int QUANTUM_WIDTH = 16,
    parameter int MTU_BYTES     = 9600,
    parameter int BUS_BYTES     = 64,
    parameter int DEFICIT_WIDTH = deficit_width(MTU_BYTES, QUANTUM_WIDTH)
) (
    input  logic                           clk_ifc,
    input  logic                           sreset_ifc,
    p4_router_ingress_dwrr_sched_if.master bus
);
    localparam int IDX_W   = index_width(NUM_PORTS);
    localparam int BYTES_W = $clog2(BUS_BYTES + 1);
    localparam int SUM_W   = DEFICIT_WIDTH + 1;
    localparam logic signed [SUM_W-1:0] c_DEF_MAX = {2'b00, {(DEFICIT_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] c_DEF_MIN = -(SUM_W'(MTU_BYTES));

    dwrr_state_t                     r_state;
    logic [IDX_W-1:0]                r_ptr;
    logic [IDX_W-1:0]                r_grant_index;
    logic [NUM_PORTS-1:0]            r_grant;
    logic                            r_grant_valid;
    logic signed [DEFICIT_WIDTH-1:0] r_deficit [NUM_PORTS];
    logic [31:0]                     r_replenish_cnt;

    logic [NUM_PORTS-1:0]            w_eligible;
    logic [NUM_PORTS-1:0]            w_backlog;
    logic [NUM_PORTS-1:0]            w_pick_onehot;
    logic [IDX_W-1:0]                w_pick_index;
    logic                            w_pick_any;
    logic signed [SUM_W-1:0]         w_sum [NUM_PORTS];
    logic signed [DEFICIT_WIDTH-1:0] w_sat [NUM_PORTS];
    logic [BYTES_W-1:0]              w_bytes;
    logic signed [DEFICIT_WIDTH-1:0] w_gdef;
    logic signed [SUM_W-1:0]         w_diff;
    logic signed [DEFICIT_WIDTH-1:0] w_debited;
    logic                            w_ptr_stay;
    logic [IDX_W-1:0]                w_ptr_next;

    assign w_bytes = bus.xfer_bytes;

    // Eligibility, backlog and the saturating replenish value per port.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_eligible[i] = bus.port_req[i] & bus.port_enable[i]
                          & ~r_deficit[i][DEFICIT_WIDTH-1] & (r_deficit[i] != '0);
            w_backlog[i]  = bus.port_req[i] & bus.port_enable[i] & (bus.quantum[i] != '0);
            w_sum[i]      = {r_deficit[i][DEFICIT_WIDTH-1], r_deficit[i]} + SUM_W'(bus.quantum[i]);
            w_sat[i]      = (w_sum[i] > c_DEF_MAX) ? c_DEF_MAX[DEFICIT_WIDTH-1:0]
                                                   : w_sum[i][DEFICIT_WIDTH-1:0];
        end
    end

    p4_router_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req    (w_eligible),
        .ptr    (r_ptr),
        .onehot (w_pick_onehot),
        .index  (w_pick_index),
        .any    (w_pick_any)
    );

    // Debit of the granted port, floored at -MTU so a runaway packet cannot
    // push the deficit past what one future quantum range can recover.
    assign w_gdef     = r_deficit[r_grant_index];
    assign w_diff     = {w_gdef[DEFICIT_WIDTH-1], w_gdef} - SUM_W'(w_bytes);
    assign w_debited  = (w_diff < c_DEF_MIN) ? c_DEF_MIN[DEFICIT_WIDTH-1:0]
                                             : w_diff[DEFICIT_WIDTH-1:0];
    // A port that still has credit and more traffic keeps priority.
    assign w_ptr_stay = bus.port_req[r_grant_index] & ~w_debited[DEFICIT_WIDTH-1]
                      & (w_debited != '0);
    assign w_ptr_next = w_ptr_stay ? r_grant_index
                      : (r_grant_index == IDX_W'(NUM_PORTS - 1)) ? '0
                      : r_grant_index + 1'b1;

    always_ff @(posedge clk_ifc) begin
        if (sreset_ifc) begin
            r_state         <= ARB;
            r_ptr           <= '0;
            r_grant         <= '0;
            r_grant_valid   <= 1'b0;
            r_grant_index   <= '0;
            r_replenish_cnt <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_deficit[i] <= '0;
            end
        end else begin
            // Disabled ports lose their credit unless they own the bus; the
            // granted port keeps being debited until its packet ends.
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!bus.port_enable[i] && !(r_grant_valid && r_grant[i])) begin
                    r_deficit[i] <= '0;
                end
            end

            case (r_state)
                ARB: begin
                    if (w_pick_any) begin
                        r_grant       <= w_pick_onehot;
                        r_grant_valid <= 1'b1;
                        r_grant_index <= w_pick_index;
                        r_state       <= XFER;
                    end else if (|w_backlog) begin
                        r_state <= REPLENISH;
                    end
                end

                REPLENISH: begin
                    // Ports with nothing to send forfeit any credit.
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        r_deficit[i] <= w_backlog[i] ? w_sat[i] : '0;
                    end
                    r_replenish_cnt <= r_replenish_cnt + 32'd1;
                    r_state         <= ARB;
                end

                XFER: begin
                    if (bus.xfer_valid && r_grant_valid) begin
                        r_deficit[r_grant_index] <= w_debited;
                        if (bus.xfer_last) begin
                            r_grant       <= '0;
                            r_grant_valid <= 1'b0;
                            r_ptr         <= w_ptr_next;
                            r_state       <= ARB;
                        end
                    end
                end

                default: r_state <= ARB;
            endcase
        end
    end

    assign bus.grant         = r_grant;
    assign bus.grant_valid   = r_grant_valid;
    assign bus.grant_index   = r_grant_index;
    assign bus.replenish_cnt = r_replenish_cnt;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_deficit_out
            assign bus.deficit[gi] = r_deficit[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_p4_router_ingress_dwrr_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_p4_router_ingress_dwrr_sched                                |
// | Purpose : Directed self-checking bench for the ingress DWRR scheduler.   |
// |           A second instance with a narrow deficit exercises saturation.  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_p4_router_ingress_dwrr_sched;
    import p4_router_pkg::*;

    localparam int NUM_PORTS     = 4;
    localparam int QUANTUM_WIDTH = 16;
    localparam int MTU_BYTES     = 9600;
    localparam int BUS_BYTES     = 64;
    localparam int DEFICIT_WIDTH = deficit_width(MTU_BYTES, QUANTUM_WIDTH);
    localparam int NARROW_DW     = 16;
    localparam int BYTES_W       = $clog2(BUS_BYTES + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    p4_router_ingress_dwrr_sched_if #(
        .NUM_PORTS(NUM_PORTS), .QUANTUM_WIDTH(QUANTUM_WIDTH), .MTU_BYTES(MTU_BYTES),
        .BUS_BYTES(BUS_BYTES), .DEFICIT_WIDTH(DEFICIT_WIDTH)
    ) bus ();

    p4_router_ingress_dwrr_sched_if #(
        .NUM_PORTS(NUM_PORTS), .QUANTUM_WIDTH(QUANTUM_WIDTH), .MTU_BYTES(MTU_BYTES),
        .BUS_BYTES(BUS_BYTES), .DEFICIT_WIDTH(NARROW_DW)
    ) bus_s ();

    assign bus_s.port_req    = bus.port_req;
    assign bus_s.port_enable = bus.port_enable;
    assign bus_s.quantum     = bus.quantum;
    assign bus_s.xfer_valid  = bus.xfer_valid;
    assign bus_s.xfer_last   = bus.xfer_last;
    assign bus_s.xfer_bytes  = bus.xfer_bytes;

    p4_router_ingress_dwrr_sched #(
        .NUM_PORTS(NUM_PORTS), .QUANTUM_WIDTH(QUANTUM_WIDTH), .MTU_BYTES(MTU_BYTES),
        .BUS_BYTES(BUS_BYTES), .DEFICIT_WIDTH(DEFICIT_WIDTH)
    ) dut (
        .clk_ifc    (clk),
        .sreset_ifc (rst),
        .bus        (bus)
    );

    p4_router_ingress_dwrr_sched #(
        .NUM_PORTS(NUM_PORTS), .QUANTUM_WIDTH(QUANTUM_WIDTH), .MTU_BYTES(MTU_BYTES),
        .BUS_BYTES(BUS_BYTES), .DEFICIT_WIDTH(NARROW_DW)
    ) dut_narrow (
        .clk_ifc    (clk),
        .sreset_ifc (rst),
        .bus        (bus_s)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.port_req    = '0;
        bus.port_enable = '0;
        bus.quantum     = '0;
        bus.xfer_valid  = 1'b0;
        bus.xfer_last   = 1'b0;
        bus.xfer_bytes  = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant(output int idx);
        int n = 0;
        while (bus.grant_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("grant_within_budget", (n < 20) ? 1 : 0, 1);
        idx = int'(bus.grant_index);
    endtask

    task automatic send_pkt(input int nbytes);
        int rem = nbytes;
        while (rem > 0) begin
            chk("gv_hold", bus.grant_valid, 1);
            bus.xfer_valid = 1'b1;
            bus.xfer_bytes = BYTES_W'((rem > BUS_BYTES) ? BUS_BYTES : rem);
            bus.xfer_last  = (rem <= BUS_BYTES);
            rem -= BUS_BYTES;
            tick();
        end
        bus.xfer_valid = 1'b0;
        bus.xfer_last  = 1'b0;
        bus.xfer_bytes = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int idx;
        int bytes [NUM_PORTS];
        int exp_idx [16] = '{0,0,0,0,0,0,1,1, 0,0,0,0,0,0,1,1};
        int exp_def [16] = '{2500,2000,1500,1000,500,0,500,0, 2500,2000,1500,1000,500,0,500,0};

        // ---- reset state, single port with replenish ----
        do_reset();
        chk("rst_grant", bus.grant, 0);
        chk("rst_gv", bus.grant_valid, 0);
        chk("rst_gidx", bus.grant_index, 0);
        chk("rst_def0", $signed(bus.deficit[0]), 0);
        chk("rst_def3", $signed(bus.deficit[3]), 0);
        chk("rst_cnt", bus.replenish_cnt, 0);

        bus.port_enable = 4'b1111;
        bus.quantum[0]  = 16'd1500;
        bus.port_req    = 4'b0001;
        tick();
        chk("t1_arb_gv", bus.grant_valid, 0);
        tick();
        chk("t1_repl_def0", $signed(bus.deficit[0]), 1500);
        chk("t1_repl_cnt", bus.replenish_cnt, 1);
        chk("t1_repl_gv", bus.grant_valid, 0);
        tick();
        chk("t1_grant", bus.grant, 4'b0001);
        chk("t1_gv", bus.grant_valid, 1);
        chk("t1_gidx", bus.grant_index, 0);
        send_pkt(1500);
        chk("t1_end_def0", $signed(bus.deficit[0]), 0);
        chk("t1_end_gv", bus.grant_valid, 0);
        chk("t1_end_grant", bus.grant, 0);
        // pointer must have advanced to port 1
        bus.quantum[1] = 16'd100;
        bus.port_req   = 4'b0011;
        wait_grant(idx);
        chk("t1_ptr_next_idx", idx, 1);
        chk("t1_ptr_def0", $signed(bus.deficit[0]), 1500);
        send_pkt(100);
        chk("t1_p1_def1", $signed(bus.deficit[1]), 0);

        // ---- weighted share 3:1 over two rounds ----
        do_reset();
        bus.port_enable = 4'b1111;
        bus.quantum[0]  = 16'd3000;
        bus.quantum[1]  = 16'd1000;
        bus.port_req    = 4'b0011;
        for (int i = 0; i < NUM_PORTS; i++) bytes[i] = 0;
        for (int p = 0; p < 16; p++) begin
            wait_grant(idx);
            chk("t2_idx", idx, exp_idx[p]);
            chk("t2_onehot", bus.grant, 64'(1) << exp_idx[p]);
            if (idx >= 0 && idx < NUM_PORTS) bytes[idx] += 500;
            send_pkt(500);
            chk("t2_def", $signed(bus.deficit[exp_idx[p]]), exp_def[p]);
        end
        chk("t2_bytes0", bytes[0], 6000);
        chk("t2_bytes1", bytes[1], 2000);
        chk("t2_cnt", bus.replenish_cnt, 2);
        bus.port_req = 4'b0000;

        // ---- req/enable drop on granted port mid-packet ----
        do_reset();
        bus.port_enable = 4'b1111;
        bus.quantum[2]  = 16'd1000;
        bus.port_req    = 4'b0100;
        wait_grant(idx);
        chk("t3_idx", idx, 2);
        for (int b = 1; b <= 10; b++) begin
            if (b == 5) begin
                bus.port_req    = 4'b0000;
                bus.port_enable = 4'b1011;
            end
            chk("t3_hold_gv", bus.grant_valid, 1);
            chk("t3_hold_grant", bus.grant, 4'b0100);
            bus.xfer_valid = 1'b1;
            bus.xfer_bytes = BYTES_W'(64);
            bus.xfer_last  = (b == 10);
            tick();
        end
        bus.xfer_valid = 1'b0;
        bus.xfer_last  = 1'b0;
        chk("t3_end_gv", bus.grant_valid, 0);
        chk("t3_end_def2", $signed(bus.deficit[2]), 360);
        tick();
        chk("t3_clear_def2", $signed(bus.deficit[2]), 0);
        bus.port_enable = 4'b1111;
        bus.quantum[0]  = 16'd100;
        bus.quantum[2]  = 16'd100;
        bus.port_req    = 4'b0101;
        wait_grant(idx);
        chk("t3_ptr_idx", idx, 0);
        send_pkt(100);
        bus.port_req = 4'b0000;

        // ---- all quanta zero: never replenish, never grant ----
        do_reset();
        bus.port_enable = 4'b1111;
        bus.port_req    = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            bus.xfer_valid = c[0];
            bus.xfer_last  = 1'b1;
            bus.xfer_bytes = BYTES_W'(64);
            tick();
        end
        bus.xfer_valid = 1'b0;
        bus.xfer_last  = 1'b0;
        chk("t4_gv", bus.grant_valid, 0);
        chk("t4_cnt", bus.replenish_cnt, 0);
        chk("t4_def0", $signed(bus.deficit[0]), 0);
        chk("t4_def3", $signed(bus.deficit[3]), 0);

        // ---- maximum quantum: no wrap, narrow instance saturates ----
        do_reset();
        bus.port_enable = 4'b1111;
        bus.quantum[0]  = 16'hFFFF;
        bus.port_req    = 4'b0001;
        tick();
        tick();
        chk("t5_def0_max_q", $signed(bus.deficit[0]), 65535);
        chk("t5_narrow_sat", $signed(bus_s.deficit[0]), 32767);
        tick();
        chk("t5_gv", bus.grant_valid, 1);

        // ---- oversized packet: deficit floors at -MTU ----
        do_reset();
        bus.port_enable = 4'b1111;
        bus.quantum[0]  = 16'd1;
        bus.port_req    = 4'b0001;
        wait_grant(idx);
        chk("t5_min_idx", idx, 0);
        send_pkt(10240);
        chk("t5_floor_def0", $signed(bus.deficit[0]), -9600);
        chk("t5_floor_narrow", $signed(bus_s.deficit[0]), -9600);
        tick();
        tick();
        chk("t5_floor_repl", $signed(bus.deficit[0]), -9599);
        chk("t5_floor_cnt", bus.replenish_cnt, 2);
        bus.port_req = 4'b0000;

        // ---- reset in the middle of a packet ----
        do_reset();
        bus.port_enable = 4'b1111;
        bus.quantum[0]  = 16'd1500;
        bus.quantum[1]  = 16'd500;
        bus.port_req    = 4'b0011;
        wait_grant(idx);
        chk("t6_idx", idx, 0);
        for (int b = 0; b < 2; b++) begin
            bus.xfer_valid = 1'b1;
            bus.xfer_bytes = BYTES_W'(64);
            bus.xfer_last  = 1'b0;
            tick();
        end
        chk("t6_mid_def0", $signed(bus.deficit[0]), 1372);
        rst = 1'b1;
        tick();
        chk("t6_rst_grant", bus.grant, 0);
        chk("t6_rst_gv", bus.grant_valid, 0);
        chk("t6_rst_def0", $signed(bus.deficit[0]), 0);
        chk("t6_rst_def1", $signed(bus.deficit[1]), 0);
        chk("t6_rst_cnt", bus.replenish_cnt, 0);
        rst = 1'b0;
        bus.xfer_valid = 1'b0;
        wait_grant(idx);
        chk("t6_resume_idx", idx, 0);
        chk("t6_resume_def0", $signed(bus.deficit[0]), 1500);
        chk("t6_resume_def1", $signed(bus.deficit[1]), 500);
        chk("t6_resume_cnt", bus.replenish_cnt, 1);
        send_pkt(1500);
        chk("t6_after_def0", $signed(bus.deficit[0]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
